// File: rtl/apb_timer_evt_ctrl_pkg.sv
// Shared types and index constants for the APB timer event/halt controller.
//   halt_state_e : debug-halt sequencer states
//   CH_LO/CH_HI  : event channel indices
//   IRQ_LO/IRQ_HI: bit positions in irq_clr_i / irq_pend_o
package apb_timer_evt_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        STOP_WAIT = 2'd1,
        HALTED    = 2'd2
    } halt_state_e;

    localparam int CH_LO  = 0;
    localparam int CH_HI  = 1;
    localparam int IRQ_LO = 0;
    localparam int IRQ_HI = 1;

endpackage

// File: rtl/apb_timer_evt_rr_arb.sv
// Round-robin arbiter for one event channel.
//   clk_i, rst_ni : clock, async active-low reset
//   req_i         : per-source request
//   gnt_o         : one-hot grant (combinational)
//   valid_o       : a grant was issued this cycle
// The search starts at the pointer; after a grant the pointer moves to the
// source just past the winner, so the winner has lowest priority next time.
module apb_timer_evt_rr_arb #(
    parameter int N = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o,
    output logic         valid_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_nxt;

    always_comb begin
        int idx;
        idx     = 0;
        gnt_o   = '0;
        valid_o = 1'b0;
        ptr_nxt = ptr_q;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!valid_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                valid_o    = 1'b1;
                ptr_nxt    = PW'((idx + 1) % N);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (valid_o) begin
            ptr_q <= ptr_nxt;
        end
    end

endmodule

// File: rtl/apb_timer_evt_ctrl.sv
// Event and halt controller in front of the APB timer.
//   clk_i, rst_ni          : clock, async active-low reset
//   src_evt_i/src_en_i     : per-source event pulse and enable
//   src_hi_sel_i           : per-source routing, 1 = event_hi, 0 = event_lo
//   event_lo_o/event_hi_o  : registered event pulses to the timer
//   halt_req_i, busy_i     : debug halt request, timer busy
//   stoptimer_o, halt_ack_o: timer stop request, halt acknowledged
//   irq_lo_i/irq_hi_i      : timer interrupts, edge-captured into irq_pend_o
//   irq_clr_i              : write-1-clear for irq_pend_o
//   ovf_o, ovf_clr_i       : sticky per-source counter overflow and its clear
//
// Halt FSM:
//   state     | meaning
//   RUN       | normal scheduling of pending events
//   STOP_WAIT | stop requested, waiting for the timer to go idle
//   HALTED    | timer stopped and idle, halt acknowledged
module apb_timer_evt_ctrl
    import apb_timer_evt_ctrl_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_SRC-1:0] src_evt_i,
    input  logic [N_SRC-1:0] src_en_i,
    input  logic [N_SRC-1:0] src_hi_sel_i,
    output logic             event_lo_o,
    output logic             event_hi_o,
    input  logic             halt_req_i,
    input  logic             busy_i,
    output logic             stoptimer_o,
    output logic             halt_ack_o,
    input  logic             irq_lo_i,
    input  logic             irq_hi_i,
    input  logic [1:0]       irq_clr_i,
    output logic [1:0]       irq_pend_o,
    output logic [N_SRC-1:0] ovf_o,
    input  logic             ovf_clr_i
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    halt_state_e      state_q;
    logic [CNT_W-1:0] cnt_q [N_SRC];
    logic [N_SRC-1:0] req [2];
    logic [N_SRC-1:0] gnt_lo;
    logic [N_SRC-1:0] gnt_hi;
    logic [N_SRC-1:0] gnt;
    logic [N_SRC-1:0] inc;
    logic [N_SRC-1:0] ovf_set;
    logic             vld_lo;
    logic             vld_hi;
    logic             run;
    logic [1:0]       irq_in;
    logic [1:0]       irq_q;

    assign run = (state_q == RUN);
    assign inc = src_evt_i & src_en_i;
    assign gnt = gnt_lo | gnt_hi;

    // A channel only requests while its own pulse is low, which guarantees
    // the low gap between back-to-back pulses.
    always_comb begin
        req[CH_LO] = '0;
        req[CH_HI] = '0;
        ovf_set    = '0;
        for (int i = 0; i < N_SRC; i++) begin
            req[CH_LO][i] = (cnt_q[i] != '0) && !src_hi_sel_i[i] && run && !event_lo_o;
            req[CH_HI][i] = (cnt_q[i] != '0) &&  src_hi_sel_i[i] && run && !event_hi_o;
            ovf_set[i]    = inc[i] && !gnt[i] && (cnt_q[i] == CNT_MAX);
        end
    end

    apb_timer_evt_rr_arb #(.N(N_SRC)) u_arb_lo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_i   (req[CH_LO]),
        .gnt_o   (gnt_lo),
        .valid_o (vld_lo)
    );

    apb_timer_evt_rr_arb #(.N(N_SRC)) u_arb_hi (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_i   (req[CH_HI]),
        .gnt_o   (gnt_hi),
        .valid_o (vld_hi)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_SRC; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_o      <= '0;
            event_lo_o <= 1'b0;
            event_hi_o <= 1'b0;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (inc[i] && !gnt[i]) begin
                    if (cnt_q[i] != CNT_MAX) begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end else if (gnt[i] && !inc[i]) begin
                    cnt_q[i] <= cnt_q[i] - 1'b1;
                end
            end
            // a fresh overflow beats a simultaneous clear
            ovf_o      <= (ovf_o & {N_SRC{!ovf_clr_i}}) | ovf_set;
            event_lo_o <= vld_lo;
            event_hi_o <= vld_hi;
        end
    end

    always_comb begin
        irq_in         = '0;
        irq_in[IRQ_LO] = irq_lo_i;
        irq_in[IRQ_HI] = irq_hi_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_q      <= '0;
            irq_pend_o <= '0;
        end else begin
            irq_q      <= irq_in;
            irq_pend_o <= (irq_pend_o & ~irq_clr_i) | (irq_in & ~irq_q);
        end
    end

    // Outputs decode the current state, so they follow a state change by
    // one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RUN;
            stoptimer_o <= 1'b0;
            halt_ack_o  <= 1'b0;
        end else begin
            stoptimer_o <= (state_q != RUN);
            halt_ack_o  <= (state_q == HALTED);
            case (state_q)
                RUN: begin
                    if (halt_req_i) state_q <= STOP_WAIT;
                end
                STOP_WAIT: begin
                    if (!halt_req_i)  state_q <= RUN;
                    else if (!busy_i) state_q <= HALTED;
                end
                HALTED: begin
                    if (!halt_req_i) state_q <= RUN;
                end
                default: state_q <= RUN;
            endcase
        end
    end

endmodule
